// File: rtl/eth_pause_ctrl_gen.sv
// Pause/PFC sideband generator: hysteresis on per-priority RX fill levels, with a periodic XOFF refresh.
// Latency: 1 cycle from fill_level/cfg to pause_xoff/pause_xon/pfc_xoff. No input pipeline.
// Backpressure: none accepted; the outputs are the backpressure request towards the MAC.
module eth_pause_ctrl_gen #(
    parameter int NUM_PRIO = 8,
    parameter int LEVEL_W  = 12,
    parameter int TMR_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_en,
    input  logic                        cfg_pfc_mode,
    input  logic [LEVEL_W-1:0]          cfg_xoff_thresh,
    input  logic [LEVEL_W-1:0]          cfg_xon_thresh,
    input  logic [TMR_W-1:0]            cfg_refresh,
    input  logic [NUM_PRIO*LEVEL_W-1:0] fill_level,
    input  logic                        mac_pfc_pause,
    output logic                        pause_xoff,
    output logic                        pause_xon,
    output logic [NUM_PRIO-1:0]         pfc_xoff,
    output logic [TMR_W-1:0]            stat_xoff_cnt,
    output logic [TMR_W-1:0]            stat_pause_rx_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XOFF = 1'b1;

    logic [NUM_PRIO-1:0] hi;
    logic [NUM_PRIO-1:0] lo;
    logic                congested;
    logic                released;
    logic                link_active;
    logic                pfc_active;

    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic [TMR_W-1:0]    timer;
    logic [TMR_W-1:0]    timer_nxt;
    logic                xoff_nxt;
    logic                xon_nxt;
    logic [NUM_PRIO-1:0] pfc_nxt;
    logic                mac_pause_q;

    // Per-priority threshold flags and the link-level aggregate (hi beats lo on overlap).
    always_comb begin
        hi = '0;
        lo = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            hi[i] = fill_level[i*LEVEL_W +: LEVEL_W] >= cfg_xoff_thresh;
            lo[i] = fill_level[i*LEVEL_W +: LEVEL_W] <= cfg_xon_thresh;
        end
        congested   = |hi;
        released    = (&lo) && !congested;
        link_active = cfg_en && !cfg_pfc_mode;
        pfc_active  = cfg_en && cfg_pfc_mode;
    end

    // Link pause FSM: release/disable outranks refresh, so an expiring timer never doubles up with XON.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        xoff_nxt  = 1'b0;
        xon_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (link_active && congested) begin
                    xoff_nxt  = 1'b1;
                    timer_nxt = cfg_refresh;
                    state_nxt = ST_XOFF;
                end
            end
            ST_XOFF: begin
                if (released || !link_active) begin
                    xon_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if ((cfg_refresh != '0) && (timer == TMR_W'(1))) begin
                    xoff_nxt  = 1'b1;
                    timer_nxt = cfg_refresh;
                end else if (timer != '0) begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-priority PFC hysteresis; leaving PFC mode clears every level so re-entry starts from 0.
    always_comb begin
        pfc_nxt = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            if (!pfc_active) begin
                pfc_nxt[i] = 1'b0;
            end else if (hi[i]) begin
                pfc_nxt[i] = 1'b1;
            end else if (lo[i]) begin
                pfc_nxt[i] = 1'b0;
            end else begin
                pfc_nxt[i] = pfc_xoff[i];
            end
        end
    end

    // Output and FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            pause_xoff <= 1'b0;
            pause_xon  <= 1'b0;
            pfc_xoff   <= '0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            pause_xoff <= xoff_nxt;
            pause_xon  <= xon_nxt;
            pfc_xoff   <= pfc_nxt;
        end
    end

    // Saturating status counters: XOFF pulses sent (incl. refreshes) and MAC pause rising edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_xoff_cnt     <= '0;
            stat_pause_rx_cnt <= '0;
            mac_pause_q       <= 1'b0;
        end else begin
            mac_pause_q <= mac_pfc_pause;
            if (xoff_nxt && (stat_xoff_cnt != '1)) begin
                stat_xoff_cnt <= stat_xoff_cnt + TMR_W'(1);
            end
            if (mac_pfc_pause && !mac_pause_q && (stat_pause_rx_cnt != '1)) begin
                stat_pause_rx_cnt <= stat_pause_rx_cnt + TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_eth_pause_ctrl_gen.sv
// Directed bench for eth_pause_ctrl_gen with an expected-output queue.
// Latency: expectations are compared 1 ns after the edge that produces them.
// Backpressure: not applicable.
module tb_eth_pause_ctrl_gen;

    typedef struct packed {
        logic       xoff;
        logic       xon;
        logic [7:0] pfc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cfg_en;
    logic        cfg_pfc_mode;
    logic [11:0] cfg_xoff_thresh;
    logic [11:0] cfg_xon_thresh;
    logic [15:0] cfg_refresh;
    logic [95:0] fill_level;
    logic        mac_pfc_pause;
    logic        pause_xoff;
    logic        pause_xon;
    logic [7:0]  pfc_xoff;
    logic [15:0] stat_xoff_cnt;
    logic [15:0] stat_pause_rx_cnt;

    // Narrow-counter instance so saturation is reachable in a short run.
    logic [3:0]  cfg_refresh2;
    logic [95:0] fill_level2;
    logic        mac_pfc_pause2;
    logic        pause_xoff2;
    logic        pause_xon2;
    logic [7:0]  pfc_xoff2;
    logic [3:0]  stat_xoff_cnt2;
    logic [3:0]  stat_pause_rx_cnt2;

    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    eth_pause_ctrl_gen #(.NUM_PRIO(8), .LEVEL_W(12), .TMR_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_en            (cfg_en),
        .cfg_pfc_mode      (cfg_pfc_mode),
        .cfg_xoff_thresh   (cfg_xoff_thresh),
        .cfg_xon_thresh    (cfg_xon_thresh),
        .cfg_refresh       (cfg_refresh),
        .fill_level        (fill_level),
        .mac_pfc_pause     (mac_pfc_pause),
        .pause_xoff        (pause_xoff),
        .pause_xon         (pause_xon),
        .pfc_xoff          (pfc_xoff),
        .stat_xoff_cnt     (stat_xoff_cnt),
        .stat_pause_rx_cnt (stat_pause_rx_cnt)
    );

    eth_pause_ctrl_gen #(.NUM_PRIO(8), .LEVEL_W(12), .TMR_W(4)) dut_sat (
        .clk               (clk),
        .rst               (rst),
        .cfg_en            (1'b1),
        .cfg_pfc_mode      (1'b0),
        .cfg_xoff_thresh   (12'd800),
        .cfg_xon_thresh    (12'd400),
        .cfg_refresh       (cfg_refresh2),
        .fill_level        (fill_level2),
        .mac_pfc_pause     (mac_pfc_pause2),
        .pause_xoff        (pause_xoff2),
        .pause_xon         (pause_xon2),
        .pfc_xoff          (pfc_xoff2),
        .stat_xoff_cnt     (stat_xoff_cnt2),
        .stat_pause_rx_cnt (stat_pause_rx_cnt2)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: sequence did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic set_fill(input int prio, input logic [11:0] val);
        fill_level[prio*12 +: 12] = val;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Push the expectation for the next edge, clock once, pop and compare against the outputs.
    task automatic step(input logic ex, input logic en, input logic [7:0] ep, input string tag);
        exp_t e;
        exp_t o;
        sb.push_back({ex, en, ep});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = {pause_xoff, pause_xon, pfc_xoff};
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: got xoff=%b xon=%b pfc=%h, want xoff=%b xon=%b pfc=%h",
                   tag, o.xoff, o.xon, o.pfc, e.xoff, e.xon, e.pfc);
        end
    endtask

    initial begin
        n_chk           = 0;
        n_fail          = 0;
        rst             = 1'b1;
        cfg_en          = 1'b0;
        cfg_pfc_mode    = 1'b0;
        cfg_xoff_thresh = 12'd800;
        cfg_xon_thresh  = 12'd400;
        cfg_refresh     = 16'd0;
        fill_level      = '0;
        mac_pfc_pause   = 1'b0;
        cfg_refresh2    = 4'd0;
        fill_level2     = '0;
        mac_pfc_pause2  = 1'b0;

        #12;
        check("rst_xoff", 32'(pause_xoff), 32'd0);
        check("rst_xon", 32'(pause_xon), 32'd0);
        check("rst_pfc", 32'(pfc_xoff), 32'd0);
        check("rst_xcnt", 32'(stat_xoff_cnt), 32'd0);
        check("rst_rxcnt", 32'(stat_pause_rx_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Link mode, no refresh: single XOFF, hold between thresholds, XON at xon threshold.
        cfg_en = 1'b1;
        step(1'b0, 1'b0, 8'h00, "link_idle");
        set_fill(3, 12'd800);
        step(1'b1, 1'b0, 8'h00, "link_xoff");
        check("link_xcnt1", 32'(stat_xoff_cnt), 32'd1);
        set_fill(3, 12'd500);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, "link_between");
        set_fill(3, 12'd400);
        step(1'b0, 1'b1, 8'h00, "link_xon");
        step(1'b0, 1'b0, 8'h00, "link_after_xon");
        check("link_xcnt_hold", 32'(stat_xoff_cnt), 32'd1);

        // Refresh every 10 cycles; release lands on the cycle the timer expires.
        cfg_refresh = 16'd10;
        set_fill(3, 12'd0);
        set_fill(0, 12'd900);
        for (int k = 1; k <= 40; k++) step((k % 10) == 1, 1'b0, 8'h00, "refresh");
        check("refresh_xcnt", 32'(stat_xoff_cnt), 32'd5);
        set_fill(0, 12'd0);
        step(1'b0, 1'b1, 8'h00, "release_at_expiry");
        step(1'b0, 1'b0, 8'h00, "release_after");
        check("release_xcnt", 32'(stat_xoff_cnt), 32'd5);

        // PFC mode hysteresis per priority.
        cfg_refresh  = 16'd0;
        cfg_pfc_mode = 1'b1;
        set_fill(2, 12'd850);
        set_fill(5, 12'd600);
        step(1'b0, 1'b0, 8'h04, "pfc_p2");
        set_fill(5, 12'd800);
        step(1'b0, 1'b0, 8'h24, "pfc_p5");
        set_fill(2, 12'd400);
        step(1'b0, 1'b0, 8'h20, "pfc_p2_clr");
        set_fill(5, 12'd600);
        step(1'b0, 1'b0, 8'h20, "pfc_p5_hold");

        // Mode switches.
        cfg_pfc_mode = 1'b0;
        step(1'b0, 1'b0, 8'h00, "pfc_off");
        set_fill(5, 12'd900);
        step(1'b1, 1'b0, 8'h00, "sw_xoff");
        step(1'b0, 1'b0, 8'h00, "sw_hold");
        cfg_pfc_mode = 1'b1;
        step(1'b0, 1'b1, 8'h20, "sw_to_pfc");
        step(1'b0, 1'b0, 8'h20, "sw_pfc_hold");
        cfg_pfc_mode = 1'b0;
        step(1'b1, 1'b0, 8'h00, "sw_to_link");
        cfg_en = 1'b0;
        step(1'b0, 1'b1, 8'h00, "en_off_xon");
        step(1'b0, 1'b0, 8'h00, "en_off_quiet");
        check("sw_xcnt", 32'(stat_xoff_cnt), 32'd7);

        // Overlapping thresholds: hi wins, then drop below xoff releases.
        cfg_en          = 1'b1;
        fill_level      = '0;
        cfg_xon_thresh  = 12'd900;
        cfg_xoff_thresh = 12'd800;
        step(1'b0, 1'b0, 8'h00, "mis_idle");
        set_fill(0, 12'd850);
        step(1'b1, 1'b0, 8'h00, "mis_xoff");
        step(1'b0, 1'b0, 8'h00, "mis_hold");
        set_fill(0, 12'd700);
        step(1'b0, 1'b1, 8'h00, "mis_xon");
        check("mis_xcnt", 32'(stat_xoff_cnt), 32'd8);

        // MAC pause edge counting.
        fill_level     = '0;
        cfg_xon_thresh = 12'd400;
        for (int k = 0; k < 3; k++) begin
            mac_pfc_pause = 1'b1;
            @(posedge clk);
            #1;
            check("rx_edge", 32'(stat_pause_rx_cnt), 32'(k + 1));
            mac_pfc_pause = 1'b0;
            @(posedge clk);
            #1;
        end
        mac_pfc_pause = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        mac_pfc_pause = 1'b0;
        @(posedge clk);
        #1;
        check("rx_level", 32'(stat_pause_rx_cnt), 32'd4);

        // Saturation on the narrow instance.
        cfg_refresh2 = 4'd1;
        fill_level2[11:0] = 12'd900;
        repeat (14) @(posedge clk);
        #1;
        check("sat_xcnt_14", 32'(stat_xoff_cnt2), 32'd14);
        repeat (6) @(posedge clk);
        #1;
        check("sat_xcnt_max", 32'(stat_xoff_cnt2), 32'd15);
        for (int k = 0; k < 14; k++) begin
            mac_pfc_pause2 = 1'b1;
            @(posedge clk);
            #1;
            mac_pfc_pause2 = 1'b0;
            @(posedge clk);
            #1;
        end
        check("sat_rx_14", 32'(stat_pause_rx_cnt2), 32'd14);
        for (int k = 0; k < 3; k++) begin
            mac_pfc_pause2 = 1'b1;
            @(posedge clk);
            #1;
            mac_pfc_pause2 = 1'b0;
            @(posedge clk);
            #1;
        end
        check("sat_rx_max", 32'(stat_pause_rx_cnt2), 32'd15);

        // Reset while the XOFF pulse is high; no XON after reset exit.
        set_fill(0, 12'd900);
        step(1'b1, 1'b0, 8'h00, "pre_rst_xoff");
        rst = 1'b1;
        #1;
        check("rst_async_xoff", 32'(pause_xoff), 32'd0);
        check("rst_async_xon", 32'(pause_xon), 32'd0);
        check("rst_async_xcnt", 32'(stat_xoff_cnt), 32'd0);
        check("rst_async_rxcnt", 32'(stat_pause_rx_cnt), 32'd0);
        fill_level = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, "post_rst_quiet");
        check("post_rst_xcnt", 32'(stat_xoff_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
